ifu_fetch: RTL
==============

# ifu_fetch

Instruction fetch unit for the single-issue NPC core. It holds the PC and issues one word fetch at a time to instruction memory over a valid/ready request and a valid response channel. It presents the fetched instruction with its PC to decode, which drives the immediate extender, register file and control. Decode or execute can redirect it on jal/jalr/taken branch, and it discards any fetch that is in flight when the redirect arrives.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded by reset.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  output  1  fetch request valid.
- req_ready  input  1  imem accepts request this cycle.
- req_addr  output  32  fetch address, always word aligned; equals the PC register.
- rsp_valid  input  1  imem returns data this cycle; one pulse per accepted request.
- rsp_data  input  32  instruction word.
- inst_valid  output  1  inst/inst_pc hold a valid instruction.
- inst_ready  input  1  decode consumes the instruction this cycle.
- inst  output  32  instruction word for decode and extender.
- inst_pc  output  32  address of inst.
- redirect_valid  input  1  control-flow redirect.
- redirect_pc  input  32  new PC; bits [1:0] are ignored and forced to 0.

## Operation
- State: `pc` (32), `inst_buf` (32), `inst_pc_buf` (32), `kill` (1), FSM {REQ, WAIT, HOLD}.
- Reset:
  - pc=RESET_PC, state=REQ, kill=0, inst_buf=0, inst_pc_buf=0.
  - req_valid and inst_valid are forced to 0 while rst=1.
- Output decode:
  - req_valid=1 only in REQ.
  - inst_valid=1 only in HOLD.
  - inst=inst_buf; inst_pc=inst_pc_buf.
- REQ:
  - On req_ready, go to WAIT.
  - Without req_ready, stay in REQ; req_addr stays stable unless a redirect occurs.
- WAIT:
  - On rsp_valid with kill=0: inst_buf←rsp_data, inst_pc_buf←pc, go to HOLD.
  - On rsp_valid with kill=1: discard the data, clear kill, go to REQ.
- HOLD:
  - On inst_ready: pc←pc+4 (mod 2^32, wraps from FFFF_FFFC to 0000_0000), go to REQ.
  - Without inst_ready: hold all outputs.
- Redirect (any state) sets pc←{redirect_pc[31:2],2'b00} and takes priority over the normal PC update:
  - REQ without req_ready: stay in REQ; the next cycle requests the new pc.
  - REQ with req_ready in the same cycle: the old-address request is accepted; go to WAIT with kill=1.
  - WAIT without rsp_valid: kill←1, stay in WAIT.
  - WAIT with rsp_valid in the same cycle: discard the data, kill←0, go to REQ.
  - HOLD, with or without inst_ready: drop the buffered instruction, go to REQ. No pc+4 is applied.
- Back-to-back redirects: the last one wins; kill stays 1 until the single outstanding response has been absorbed.
- At most one request is outstanding. rsp_valid seen outside WAIT is a protocol error; it is ignored and must be flagged by an assertion in simulation.

## Timing
- Minimum fetch-to-decode latency:
  - Request accepted in cycle N.
  - Earliest rsp_valid in cycle N+1.
  - inst_valid in cycle N+2.
- Minimum throughput: one instruction every 3 cycles (REQ, WAIT, HOLD) with zero-wait memory and inst_ready held high.
- Redirect penalty:
  - Redirect in cycle N, no request in flight: request for the new pc in cycle N+1.
  - Request in flight: request for the new pc in the cycle after the killed response arrives.
- Handshake signals must not have combinational paths: req_valid, req_addr and inst_valid depend only on registers and rst.
- First cycle after rst falls: req_valid=1, req_addr=RESET_PC.

## Test plan
- Reset fetch:
  - Stimulus: hold rst 2 cycles, req_ready=1, memory answers 1 cycle later with 32'h00000297.
  - Required response: req_addr=8000_0000; then inst_valid=1 with inst=00000297, inst_pc=8000_0000.
- Sequential stream:
  - Stimulus: inst_ready=1, zero-wait memory.
  - Required response: inst_pc sequence 8000_0000, 8000_0004, 8000_0008; one instruction every 3 cycles.
- Backpressure:
  - Stimulus: inst_ready=0 for 5 cycles in HOLD.
  - Required response: inst and inst_pc are stable, req_valid=0, pc is not advanced.
  - Then inst_ready=1: the next req_addr is inst_pc+4.
- Redirect in WAIT:
  - Stimulus: request 8000_0010 accepted; redirect_valid with redirect_pc=8000_0103 before the response; response 32'hDEADBEEF arrives 3 cycles later.
  - Required response: DEADBEEF is never presented; the next req_addr is 8000_0100.
- Simultaneous events:
  - Stimulus 1: redirect_valid together with inst_ready in HOLD, redirect_pc=8000_0200.
  - Required response 1: next req_addr=8000_0200, not inst_pc+4.
  - Stimulus 2: redirect_valid together with rsp_valid in WAIT.
  - Required response 2: the data is dropped and the FSM is in REQ on the next cycle.
- Reset mid-fetch and wrap:
  - Stimulus 1: assert rst while in WAIT.
  - Required response 1: FSM in REQ, pc=RESET_PC, kill=0.
  - Stimulus 2: redirect to FFFF_FFFC, accept the instruction.
  - Required response 2: next req_addr=0000_0000.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit.
// Holds the PC, issues word fetches over a valid/ready request channel and
// presents each returned instruction with its PC to decode. A redirect
// replaces the PC and discards whatever fetch is still in flight.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // instruction memory request channel
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  // instruction memory response channel
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  // decode-side instruction channel
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  // control-flow redirect
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   inst_buf;
  logic [XLEN-1:0]   inst_pc_buf;
  logic              kill;
  logic [XLEN-1:0]   redirect_pc_aligned;

  // Redirect targets are forced to word alignment.
  assign redirect_pc_aligned = redirect_pc & ~XLEN'(3);

  // Handshake outputs decode only from state registers and rst.
  assign req_valid  = (state == ST_REQ)  && !rst;
  assign inst_valid = (state == ST_HOLD) && !rst;
  assign req_addr   = pc;
  assign inst       = inst_buf;
  assign inst_pc    = inst_pc_buf;

  // Fetch FSM: PC sequencing, response capture and in-flight kill tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_REQ;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      inst_buf    <= '0;
      inst_pc_buf <= '0;
    end else begin
      case (state)
        ST_REQ: begin
          if (redirect_valid) begin
            pc <= redirect_pc_aligned;
          end
          if (req_ready) begin
            // The old-address request is already accepted; its response must be dropped.
            state <= ST_WAIT;
            kill  <= redirect_valid;
          end
        end

        ST_WAIT: begin
          if (redirect_valid) begin
            pc <= redirect_pc_aligned;
          end
          if (rsp_valid) begin
            if (kill || redirect_valid) begin
              kill  <= 1'b0;
              state <= ST_REQ;
            end else begin
              inst_buf    <= rsp_data;
              inst_pc_buf <= pc;
              state       <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            kill <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (redirect_valid) begin
            pc    <= redirect_pc_aligned;
            state <= ST_REQ;
          end else if (inst_ready) begin
            pc    <= pc + XLEN'(4);
            state <= ST_REQ;
          end
        end

        default: begin
          state <= ST_REQ;
        end
      endcase
    end
  end

  // A response is only legal while a request is outstanding.
  rsp_only_in_wait: assert property (
    @(posedge clk) disable iff (rst) !(rsp_valid && (state != ST_WAIT))
  );

endmodule
